// File: rtl/csr_except_ctrl_if.sv
// Registered exception-group CSR values exported by csr_except_ctrl.
interface csr_except_info #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] crmd;
    logic [DATA_WIDTH-1:0] ecfg;
    logic [DATA_WIDTH-1:0] estat;
    logic [DATA_WIDTH-1:0] era;

    modport o (output crmd, ecfg, estat, era);
    modport i (input crmd, ecfg, estat, era);
endinterface

// File: rtl/csr_except_ctrl.sv
// Exception/interrupt sequencer for CRMD/PRMD/ECFG/ESTAT/ERA/EENTRY: CSR access,
// exception entry, ERTN return and a one-cycle flush with redirect PC.
module csr_except_ctrl #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           HWI_NUM    = 8,
    parameter logic [DATA_WIDTH-1:0] EENTRY_RST = 32'h1C000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_we,
    input  logic [13:0]           csr_waddr,
    input  logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic [13:0]           csr_raddr,
    output logic [DATA_WIDTH-1:0] csr_rdata,
    input  logic                  commit_valid,
    input  logic [DATA_WIDTH-1:0] commit_pc,
    input  logic                  except_valid,
    input  logic [5:0]            except_ecode,
    input  logic [8:0]            except_esub,
    input  logic                  ertn_valid,
    input  logic [HWI_NUM-1:0]    hw_int,
    output logic                  ready,
    output logic                  int_pending,
    output logic                  flush,
    output logic [DATA_WIDTH-1:0] flush_pc,
    csr_except_info.o             info
);
    localparam logic [13:0] ADDR_CRMD   = 14'h0;
    localparam logic [13:0] ADDR_PRMD   = 14'h1;
    localparam logic [13:0] ADDR_ECFG   = 14'h4;
    localparam logic [13:0] ADDR_ESTAT  = 14'h5;
    localparam logic [13:0] ADDR_ERA    = 14'h6;
    localparam logic [13:0] ADDR_EENTRY = 14'hC;

    localparam logic [DATA_WIDTH-1:0] CRMD_WMASK   = 'h1FF;
    localparam logic [DATA_WIDTH-1:0] PRMD_WMASK   = 'h7;
    localparam logic [DATA_WIDTH-1:0] ECFG_WMASK   = 'h1BFF;
    localparam logic [DATA_WIDTH-1:0] ESTAT_WMASK  = 'h3;
    localparam logic [DATA_WIDTH-1:0] EENTRY_WMASK = 'hFFFF_FFC0;
    localparam logic [DATA_WIDTH-1:0] CRMD_RST     = 'h8;

    typedef enum logic {StIdle, StFlush} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d;
    logic [DATA_WIDTH-1:0] estat_q, estat_d, era_q, era_d, eentry_q, eentry_d;
    logic [DATA_WIDTH-1:0] flush_pc_q, flush_pc_d;

    logic take_int, take_exc, take_ertn;

    assign int_pending = crmd_q[2] & (|(estat_q[12:0] & ecfg_q[12:0]));
    assign take_int    = commit_valid & int_pending;
    assign take_exc    = take_int | (commit_valid & except_valid);
    assign take_ertn   = commit_valid & ertn_valid;

    always_comb begin
        state_d    = state_q;
        crmd_d     = crmd_q;
        prmd_d     = prmd_q;
        ecfg_d     = ecfg_q;
        estat_d    = estat_q;
        era_d      = era_q;
        eentry_d   = eentry_q;
        flush_pc_d = flush_pc_q;
        unique case (state_q)
            StIdle: begin
                if (take_exc) begin
                    prmd_d[2:0]     = crmd_q[2:0];
                    crmd_d[2:0]     = 3'b000;
                    estat_d[21:16]  = take_int ? 6'd0 : except_ecode;
                    estat_d[30:22]  = take_int ? 9'd0 : except_esub;
                    era_d           = commit_pc;
                    flush_pc_d      = eentry_q;
                    state_d         = StFlush;
                end else if (take_ertn) begin
                    crmd_d[2:0] = prmd_q[2:0];
                    flush_pc_d  = era_q;
                    state_d     = StFlush;
                end else if (csr_we) begin
                    case (csr_waddr)
                        ADDR_CRMD:   crmd_d   = (crmd_q & ~CRMD_WMASK) | (csr_wdata & CRMD_WMASK);
                        ADDR_PRMD:   prmd_d   = (prmd_q & ~PRMD_WMASK) | (csr_wdata & PRMD_WMASK);
                        ADDR_ECFG:   ecfg_d   = (ecfg_q & ~ECFG_WMASK) | (csr_wdata & ECFG_WMASK);
                        ADDR_ESTAT:  estat_d  = (estat_q & ~ESTAT_WMASK) | (csr_wdata & ESTAT_WMASK);
                        ADDR_ERA:    era_d    = csr_wdata;
                        ADDR_EENTRY: eentry_d = (eentry_q & ~EENTRY_WMASK)
                                                | (csr_wdata & EENTRY_WMASK);
                        default: ;
                    endcase
                end
            end
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Hardware interrupt lines are tracked in every state.
        estat_d[2 +: HWI_NUM] = hw_int;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            crmd_q     <= CRMD_RST;
            prmd_q     <= '0;
            ecfg_q     <= '0;
            estat_q    <= '0;
            era_q      <= '0;
            eentry_q   <= EENTRY_RST;
            flush_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            crmd_q     <= crmd_d;
            prmd_q     <= prmd_d;
            ecfg_q     <= ecfg_d;
            estat_q    <= estat_d;
            era_q      <= era_d;
            eentry_q   <= eentry_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            ADDR_CRMD:   csr_rdata = crmd_q;
            ADDR_PRMD:   csr_rdata = prmd_q;
            ADDR_ECFG:   csr_rdata = ecfg_q;
            ADDR_ESTAT:  csr_rdata = estat_q;
            ADDR_ERA:    csr_rdata = era_q;
            ADDR_EENTRY: csr_rdata = eentry_q;
            default:     csr_rdata = '0;
        endcase
    end

    assign ready      = (state_q == StIdle);
    assign flush      = (state_q == StFlush);
    assign flush_pc   = flush_pc_q;
    assign info.crmd  = crmd_q;
    assign info.ecfg  = ecfg_q;
    assign info.estat = estat_q;
    assign info.era   = era_q;
endmodule

// File: tb/tb_csr_except_ctrl.sv
// Self-checking bench for csr_except_ctrl: directed scenarios plus random traffic
// compared against a behavioural register-file model.
module tb_csr_except_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        csr_we;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        except_valid;
    logic [5:0]  except_ecode;
    logic [8:0]  except_esub;
    logic        ertn_valid;
    logic [7:0]  hw_int;
    logic        ready;
    logic        int_pending;
    logic        flush;
    logic [31:0] flush_pc;

    csr_except_info #(.DATA_WIDTH(32)) info_if ();

    csr_except_ctrl #(
        .DATA_WIDTH(32),
        .HWI_NUM   (8),
        .EENTRY_RST(32'h1C000000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_we      (csr_we),
        .csr_waddr   (csr_waddr),
        .csr_wdata   (csr_wdata),
        .csr_raddr   (csr_raddr),
        .csr_rdata   (csr_rdata),
        .commit_valid(commit_valid),
        .commit_pc   (commit_pc),
        .except_valid(except_valid),
        .except_ecode(except_ecode),
        .except_esub (except_esub),
        .ertn_valid  (ertn_valid),
        .hw_int      (hw_int),
        .ready       (ready),
        .int_pending (int_pending),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .info        (info_if.o)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_eentry, m_fpc;
    bit          m_busy;

    function automatic void model_reset();
        m_crmd   = 32'h8;
        m_prmd   = 0;
        m_ecfg   = 0;
        m_estat  = 0;
        m_era    = 0;
        m_eentry = 32'h1C000000;
        m_fpc    = 0;
        m_busy   = 0;
    endfunction

    function automatic bit model_intp();
        return m_crmd[2] && ((m_estat[12:0] & m_ecfg[12:0]) != 13'd0);
    endfunction

    function automatic logic [31:0] model_read(input logic [13:0] a);
        case (a)
            14'h0:   return m_crmd;
            14'h1:   return m_prmd;
            14'h4:   return m_ecfg;
            14'h5:   return m_estat;
            14'h6:   return m_era;
            14'hC:   return m_eentry;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] mask);
        return (old & ~mask) | (wd & mask);
    endfunction

    task automatic idle();
        csr_we       = 0;
        commit_valid = 0;
        except_valid = 0;
        ertn_valid   = 0;
    endtask

    // Check current outputs against the model, then advance one clock.
    task automatic tick();
        logic [31:0] n_crmd, n_prmd, n_ecfg, n_estat, n_era, n_eentry, n_fpc;
        bit          n_busy, intp;
        #1;
        check("ready", 32'(ready), 32'(!m_busy));
        check("flush", 32'(flush), 32'(m_busy));
        if (m_busy) check("flush_pc", flush_pc, m_fpc);
        check("int_pending", 32'(int_pending), 32'(model_intp()));
        check("csr_rdata", csr_rdata, model_read(csr_raddr));
        check("info.crmd", info_if.crmd, m_crmd);
        check("info.ecfg", info_if.ecfg, m_ecfg);
        check("info.estat", info_if.estat, m_estat);
        check("info.era", info_if.era, m_era);
        {n_crmd, n_prmd, n_ecfg, n_estat, n_era, n_eentry, n_fpc} =
            {m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_eentry, m_fpc};
        n_busy = 0;
        intp   = model_intp();
        if (!m_busy) begin
            if (commit_valid && (intp || except_valid)) begin
                n_prmd[2:0]   = m_crmd[2:0];
                n_crmd[2:0]   = 0;
                n_estat[21:16] = intp ? 6'd0 : except_ecode;
                n_estat[30:22] = intp ? 9'd0 : except_esub;
                n_era  = commit_pc;
                n_fpc  = m_eentry;
                n_busy = 1;
            end else if (commit_valid && ertn_valid) begin
                n_crmd[2:0] = m_prmd[2:0];
                n_fpc  = m_era;
                n_busy = 1;
            end else if (csr_we) begin
                case (csr_waddr)
                    14'h0: n_crmd   = merge(m_crmd, csr_wdata, 32'h1FF);
                    14'h1: n_prmd   = merge(m_prmd, csr_wdata, 32'h7);
                    14'h4: n_ecfg   = merge(m_ecfg, csr_wdata, 32'h1BFF);
                    14'h5: n_estat  = merge(m_estat, csr_wdata, 32'h3);
                    14'h6: n_era    = csr_wdata;
                    14'hC: n_eentry = merge(m_eentry, csr_wdata, 32'hFFFF_FFC0);
                    default: ;
                endcase
            end
        end
        n_estat[9:2] = hw_int;
        @(posedge clk);
        {m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_eentry, m_fpc} =
            {n_crmd, n_prmd, n_ecfg, n_estat, n_era, n_eentry, n_fpc};
        m_busy = n_busy;
        @(negedge clk);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        csr_we    = 1;
        csr_waddr = a;
        csr_wdata = d;
        tick();
        idle();
    endtask

    logic [13:0] addr_pool[8] = '{14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'hC, 14'h2, 14'h100};

    initial begin
        rst = 1;
        idle();
        hw_int       = 0;
        csr_waddr    = 0;
        csr_wdata    = 0;
        csr_raddr    = 14'hC;
        commit_pc    = 0;
        except_ecode = 0;
        except_esub  = 0;
        model_reset();
        #12;
        check("rst_crmd", info_if.crmd, 32'h8);
        check("rst_estat", info_if.estat, 32'h0);
        check("rst_eentry", csr_rdata, 32'h1C000000);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_ready", 32'(ready), 32'h1);
        @(negedge clk);
        rst = 0;

        // Exception entry
        wr(14'h0, 32'h7);
        wr(14'hC, 32'h1C008000);
        commit_valid = 1; except_valid = 1; except_ecode = 6'hB; commit_pc = 32'h1C000100;
        tick();
        idle();
        csr_raddr = 14'h1;
        #1;
        check("exc_flush", 32'(flush), 32'h1);
        check("exc_flush_pc", flush_pc, 32'h1C008000);
        check("exc_prmd", csr_rdata, 32'h7);
        check("exc_crmd_lo", 32'(info_if.crmd[2:0]), 32'h0);
        check("exc_ecode", 32'(info_if.estat[21:16]), 32'hB);
        check("exc_era", info_if.era, 32'h1C000100);
        tick();

        // ERTN
        commit_valid = 1; ertn_valid = 1;
        tick();
        idle();
        check("ertn_flush", 32'(flush), 32'h1);
        check("ertn_flush_pc", flush_pc, 32'h1C000100);
        check("ertn_crmd_lo", 32'(info_if.crmd[2:0]), 32'h7);
        tick();

        // Interrupt
        wr(14'h4, 32'h4);
        hw_int = 8'h01;
        tick();
        check("int_pending", 32'(int_pending), 32'h1);
        commit_valid = 1; commit_pc = 32'h200;
        tick();
        idle();
        hw_int = 0;
        check("int_ecode", 32'(info_if.estat[21:16]), 32'h0);
        check("int_era", info_if.era, 32'h200);
        check("int_ie", 32'(info_if.crmd[2]), 32'h0);
        tick();

        // Priority: entry wins over ERTN and same-cycle ERA write
        commit_valid = 1; except_valid = 1; ertn_valid = 1; except_ecode = 6'h3;
        commit_pc = 32'h300; csr_we = 1; csr_waddr = 14'h6; csr_wdata = 32'hDEAD;
        tick();
        idle();
        check("prio_flush_pc", flush_pc, 32'h1C008000);
        check("prio_era", info_if.era, 32'h300);
        tick();
        check("prio_era_kept", info_if.era, 32'h300);

        // Busy: held exception ignored during FLUSH
        commit_valid = 1; except_valid = 1; commit_pc = 32'h400;
        tick();
        check("busy_flush", 32'(flush), 32'h1);
        check("busy_ready", 32'(ready), 32'h0);
        tick();
        idle();
        check("busy_one_pulse", 32'(flush), 32'h0);
        check("busy_ready_back", 32'(ready), 32'h1);
        tick();

        // Reset asserted mid-FLUSH
        commit_valid = 1; except_valid = 1; commit_pc = 32'h500;
        tick();
        idle();
        rst = 1;
        csr_raddr = 14'h6;
        #1;
        check("midrst_flush", 32'(flush), 32'h0);
        check("midrst_crmd", info_if.crmd, 32'h8);
        check("midrst_era", csr_rdata, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            csr_we       = ($urandom_range(0, 9) < 4);
            csr_waddr    = addr_pool[$urandom_range(0, 7)];
            csr_wdata    = $urandom;
            csr_raddr    = addr_pool[$urandom_range(0, 7)];
            commit_valid = $urandom_range(0, 1) == 1;
            except_valid = ($urandom_range(0, 9) < 2);
            ertn_valid   = ($urandom_range(0, 9) < 2);
            except_ecode = 6'($urandom);
            except_esub  = 9'($urandom);
            commit_pc    = $urandom;
            hw_int       = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
